// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings, FSM state type and the Wishbone sel decoder
// used by the Wishbone-to-AHB master port.
package ahb3lite_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] size;
    logic [1:0] offset;
  } sel_dec_t;

  // Contiguous naturally-aligned lane groups only; anything else is unsupported.
  function automatic sel_dec_t sel2size(input logic [SEL_W-1:0] sel);
    sel_dec_t d;
    d.valid  = 1'b1;
    d.size   = HSIZE_WORD;
    d.offset = 2'b00;
    case (sel)
      4'b1111: begin d.size = HSIZE_WORD; d.offset = 2'b00; end
      4'b0011: begin d.size = HSIZE_HALF; d.offset = 2'b00; end
      4'b1100: begin d.size = HSIZE_HALF; d.offset = 2'b10; end
      4'b0001: begin d.size = HSIZE_BYTE; d.offset = 2'b00; end
      4'b0010: begin d.size = HSIZE_BYTE; d.offset = 2'b01; end
      4'b0100: begin d.size = HSIZE_BYTE; d.offset = 2'b10; end
      4'b1000: begin d.size = HSIZE_BYTE; d.offset = 2'b11; end
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/wb_ahb3lite_master_port.sv
// Replays each Wishbone classic single cycle as one AHB3-Lite SINGLE transfer
// (NONSEQ then IDLE), returning one ack or err pulse per accepted request.
module wb_ahb3lite_master_port
  import ahb3lite_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL   = 4'b0011,
  parameter bit         BAD_SEL_ERR = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic [SEL_W-1:0]  wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              mHSEL,
  output logic [ADDR_W-1:0] mHADDR,
  output logic              mHWRITE,
  output logic [2:0]        mHSIZE,
  output logic [2:0]        mHBURST,
  output logic [3:0]        mHPROT,
  output logic [1:0]        mHTRANS,
  output logic [DATA_W-1:0] mHWDATA,
  input  logic [DATA_W-1:0] mHRDATA,
  input  logic              mHREADY,
  input  logic              mHRESP
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [2:0]        hsize_q, hsize_d;
  logic              hwrite_q, hwrite_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              hsel_q, hsel_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              abort_q, abort_d;

  sel_dec_t sel_dec_c;
  logic     deliver_c;
  logic     adr_lsb_unused;

  assign sel_dec_c      = sel2size(wb_sel_i);
  assign adr_lsb_unused = ^wb_adr_i[1:0];
  // A master that dropped cyc mid-transfer no longer expects a response.
  assign deliver_c      = wb_cyc_i & ~abort_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hsize_d  = hsize_q;
    hwrite_d = hwrite_q;
    htrans_d = HTRANS_IDLE;
    hsel_d   = 1'b0;
    wdat_d   = wdat_q;
    hwdata_d = hwdata_q;
    rdata_d  = rdata_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    abort_d  = abort_q | ~wb_cyc_i;

    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (wb_cyc_i && wb_stb_i) begin
          if (!sel_dec_c.valid && BAD_SEL_ERR) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            haddr_d  = {wb_adr_i[ADDR_W-1:2], sel_dec_c.offset};
            hsize_d  = sel_dec_c.size;
            hwrite_d = wb_we_i;
            wdat_d   = wb_dat_i;
            htrans_d = HTRANS_NONSEQ;
            hsel_d   = 1'b1;
            state_d  = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (mHREADY) begin
          hwdata_d = wdat_q;
          state_d  = ST_DATA;
        end else begin
          htrans_d = HTRANS_NONSEQ;
          hsel_d   = 1'b1;
        end
      end
      ST_DATA: begin
        if (mHREADY) begin
          if (mHRESP == HRESP_ERROR) begin
            err_d = deliver_c;
          end else begin
            ack_d = deliver_c;
            if (!hwrite_q) rdata_d = mHRDATA;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      haddr_q  <= '0;
      hsize_q  <= '0;
      hwrite_q <= 1'b0;
      htrans_q <= HTRANS_IDLE;
      hsel_q   <= 1'b0;
      wdat_q   <= '0;
      hwdata_q <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hsize_q  <= hsize_d;
      hwrite_q <= hwrite_d;
      htrans_q <= htrans_d;
      hsel_q   <= hsel_d;
      wdat_q   <= wdat_d;
      hwdata_q <= hwdata_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      abort_q  <= abort_d;
    end
  end

  assign wb_dat_o = rdata_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign mHSEL    = hsel_q;
  assign mHADDR   = haddr_q;
  assign mHWRITE  = hwrite_q;
  assign mHSIZE   = hsize_q;
  assign mHBURST  = HBURST_SINGLE;
  assign mHPROT   = HPROT_VAL;
  assign mHTRANS  = htrans_q;
  assign mHWDATA  = hwdata_q;

endmodule
